// File: rtl/axis_join_arb.sv
// N-input AXI-Stream join: one holding register per input channel, a fixed-priority or
// round-robin arbiter with optional packet lock, and a registered output carrying the source index.
module axis_join_arb #(
    parameter int DATA_WD  = 64,
    parameter int CH_NUM   = 4,
    parameter int ARB_MODE = 0,
    parameter int PKT_LOCK = 1,
    parameter int ID_WD    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH_NUM-1:0]         s_axis_tvalid,
    input  logic [CH_NUM*DATA_WD-1:0] s_axis_tdata,
    input  logic [CH_NUM-1:0]         s_axis_tlast,
    output logic [CH_NUM-1:0]         s_axis_tready,
    output logic                      m_axis_tvalid,
    output logic [DATA_WD-1:0]        m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic [ID_WD-1:0]          m_axis_tid,
    input  logic                      m_axis_tready
);

    // Per-channel holding registers.
    logic [CH_NUM-1:0]  hv_reg;
    logic [CH_NUM-1:0]  hl_reg;
    logic [DATA_WD-1:0] hd_reg [CH_NUM];

    // Output register.
    logic               m_valid_reg;
    logic               m_last_reg;
    logic [DATA_WD-1:0] m_data_reg;
    logic [ID_WD-1:0]   m_tid_reg;

    // Arbitration state.
    logic               lock_reg;
    logic               lock_next;
    logic [ID_WD-1:0]   lock_ch_reg;
    logic [ID_WD-1:0]   lock_ch_next;
    logic [ID_WD-1:0]   rr_ptr_reg;
    logic [ID_WD-1:0]   rr_ptr_next;

    // Combinational arbitration signals.
    logic               out_ready;
    logic [CH_NUM-1:0]  eligible;
    logic [CH_NUM-1:0]  s_hs;
    logic [CH_NUM-1:0]  pop_vec;
    logic [ID_WD-1:0]   scan_start;
    logic [ID_WD:0]     scan_sum;
    logic [ID_WD:0]     rr_sum;
    logic               grant_found;
    logic [ID_WD-1:0]   grant_idx;
    logic               do_pop;
    logic               pop_last;

    assign out_ready = !m_valid_reg || m_axis_tready;

    // While a packet is locked only its channel may be granted, even if it is momentarily empty.
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        assign eligible[gi]      = hv_reg[gi] && (!lock_reg || (lock_ch_reg == ID_WD'(gi)));
        assign pop_vec[gi]       = do_pop && (grant_idx == ID_WD'(gi));
        assign s_axis_tready[gi] = rst_n && (!hv_reg[gi] || pop_vec[gi]);
        assign s_hs[gi]          = s_axis_tvalid[gi] && s_axis_tready[gi];
    end

    // Fixed priority is a round-robin scan that always starts at channel 0.
    assign scan_start = (ARB_MODE == 1) ? rr_ptr_reg : '0;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            scan_sum = {1'b0, scan_start} + (ID_WD+1)'(k);
            if (scan_sum >= (ID_WD+1)'(CH_NUM)) begin
                scan_sum = scan_sum - (ID_WD+1)'(CH_NUM);
            end
            if (!grant_found && eligible[scan_sum[ID_WD-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[ID_WD-1:0];
            end
        end
    end

    assign do_pop   = grant_found && out_ready;
    assign pop_last = hl_reg[grant_idx];

    // Lock and round-robin pointer next state.
    always_comb begin
        lock_next    = lock_reg;
        lock_ch_next = lock_ch_reg;
        rr_ptr_next  = rr_ptr_reg;
        rr_sum       = {1'b0, grant_idx} + (ID_WD+1)'(1);
        if (rr_sum >= (ID_WD+1)'(CH_NUM)) begin
            rr_sum = '0;
        end
        if (do_pop) begin
            if (PKT_LOCK != 0) begin
                if (pop_last) begin
                    lock_next   = 1'b0;
                    rr_ptr_next = rr_sum[ID_WD-1:0];
                end else begin
                    lock_next    = 1'b1;
                    lock_ch_next = grant_idx;
                end
            end else begin
                rr_ptr_next = rr_sum[ID_WD-1:0];
            end
        end
    end

    // Holding registers: a load in the same cycle as a pop keeps the channel at full rate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hv_reg <= '0;
            hl_reg <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                hd_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (s_hs[i]) begin
                    hv_reg[i] <= 1'b1;
                    hl_reg[i] <= s_axis_tlast[i];
                    hd_reg[i] <= s_axis_tdata[i*DATA_WD +: DATA_WD];
                end else if (pop_vec[i]) begin
                    hv_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_data_reg  <= '0;
            m_tid_reg   <= '0;
        end else if (do_pop) begin
            m_valid_reg <= 1'b1;
            m_last_reg  <= pop_last;
            m_data_reg  <= hd_reg[grant_idx];
            m_tid_reg   <= grant_idx;
        end else if (m_axis_tready) begin
            m_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_reg    <= 1'b0;
            lock_ch_reg <= '0;
            rr_ptr_reg  <= '0;
        end else begin
            lock_reg    <= lock_next;
            lock_ch_reg <= lock_ch_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tlast  = m_last_reg;
    assign m_axis_tid    = m_tid_reg;

endmodule

// File: tb/tb_axis_join_arb.sv
// Directed bench for axis_join_arb: instance 0 is fixed-priority without lock,
// instance 1 is round-robin with packet lock; a per-channel scoreboard tracks every beat.
module tb_axis_join_arb;

    localparam int DW = 16;
    localparam int CH = 4;
    localparam int IW = 2;

    typedef struct {
        int            dly;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [CH-1:0]     s_valid [2];
    logic [CH*DW-1:0]  s_data  [2];
    logic [CH-1:0]     s_last  [2];
    logic [CH-1:0]     s_ready [2];
    logic              m_valid [2];
    logic [DW-1:0]     m_data  [2];
    logic              m_last  [2];
    logic [IW-1:0]     m_tid   [2];
    logic              m_ready [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        axis_join_arb #(
            .DATA_WD (DW),
            .CH_NUM  (CH),
            .ARB_MODE(gi),
            .PKT_LOCK(gi),
            .ID_WD   (IW)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .s_axis_tvalid(s_valid[gi]),
            .s_axis_tdata (s_data[gi]),
            .s_axis_tlast (s_last[gi]),
            .s_axis_tready(s_ready[gi]),
            .m_axis_tvalid(m_valid[gi]),
            .m_axis_tdata (m_data[gi]),
            .m_axis_tlast (m_last[gi]),
            .m_axis_tid   (m_tid[gi]),
            .m_axis_tready(m_ready[gi])
        );
    end

    beat_t          src_q [CH][$];
    logic [DW:0]    exp_q [CH][$];
    int             out_tid [$];
    int             out_cyc [$];
    logic [DW-1:0]  out_data [$];

    int             cur;
    int             cyc;
    int             last_in_cyc;
    int             n_tests;
    int             n_fail;
    bit             rand_ready;
    bit             stall_prev;
    logic           prev_last;
    logic [IW-1:0]  prev_tid;
    logic [DW-1:0]  prev_data;
    bit             lk_act;
    int             lk_tid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit busy();
        for (int ch = 0; ch < CH; ch++) begin
            if (src_q[ch].size() != 0 || exp_q[ch].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock of stimulus and observation; entered and left at a falling edge.
    task automatic cycle();
        beat_t b;
        int    t;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = '0;
            s_last[d]  = '0;
            s_data[d]  = '0;
            m_ready[d] = 1'b1;
        end
        for (int ch = 0; ch < CH; ch++) begin
            if (src_q[ch].size() != 0) begin
                b = src_q[ch][0];
                if (b.dly > 0) begin
                    b.dly--;
                    src_q[ch][0] = b;
                end else begin
                    s_valid[cur][ch]          = 1'b1;
                    s_data[cur][ch*DW +: DW]  = b.data;
                    s_last[cur][ch]           = b.last;
                end
            end
        end
        if (rand_ready) m_ready[cur] = 1'($urandom_range(0, 1));
        #1;
        if (stall_prev) begin
            check("stall_stable", {m_valid[cur], m_last[cur], m_tid[cur], m_data[cur]},
                  {1'b1, prev_last, prev_tid, prev_data});
        end
        for (int ch = 0; ch < CH; ch++) begin
            if (s_valid[cur][ch] && s_ready[cur][ch]) begin
                b = src_q[ch].pop_front();
                exp_q[ch].push_back({b.last, b.data});
                last_in_cyc = cyc;
            end
        end
        if (m_valid[cur] && m_ready[cur]) begin
            t = int'(m_tid[cur]);
            $display("[TB] cyc=%0d dut=%0d tid=%0d data=0x%0h last=%0b", cyc, cur, t, m_data[cur], m_last[cur]);
            if (exp_q[t].size() == 0) check("spurious_beat", 1, 0);
            else check("beat_data", {m_last[cur], m_data[cur]}, exp_q[t].pop_front());
            if (cur == 1) begin
                if (lk_act) check("pkt_contig", t, lk_tid);
                lk_act = !m_last[cur];
                lk_tid = t;
            end
            out_tid.push_back(t);
            out_cyc.push_back(cyc);
            out_data.push_back(m_data[cur]);
        end
        stall_prev = m_valid[cur] && !m_ready[cur];
        prev_last  = m_last[cur];
        prev_tid   = m_tid[cur];
        prev_data  = m_data[cur];
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit all_valid);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = {CH{all_valid}};
            s_last[d]  = {CH{all_valid}};
            s_data[d]  = {(CH*DW){all_valid}};
            m_ready[d] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                check("rst_tready", s_ready[d], 0);
                if (i > 0) begin
                    check("rst_mvalid", m_valid[d], 0);
                    check("rst_mdata", {m_last[d], m_tid[d], m_data[d]}, 0);
                end
            end
            @(negedge clk);
        end
        for (int ch = 0; ch < CH; ch++) begin
            src_q[ch].delete();
            exp_q[ch].delete();
        end
        out_tid.delete();
        out_cyc.delete();
        out_data.delete();
        stall_prev = 1'b0;
        lk_act     = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (busy() && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_timeout", busy(), 0);
    endtask

    function automatic beat_t mk(input int dly, input int data, input bit last);
        beat_t b;
        b.dly  = dly;
        b.data = DW'(data);
        b.last = last;
        return b;
    endfunction

    initial begin : watchdog
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        last_in_cyc = 0;
        rand_ready = 1'b0;
        cur = 1;
        @(negedge clk);

        // Reset with all inputs valid, then a lone beat on channel 2.
        do_reset(1'b1);
        src_q[2].push_back(mk(0, 'hA5, 1'b1));
        drain(20);
        check("idle_count", out_tid.size(), 1);
        if (out_tid.size() == 1) begin
            check("idle_tid", out_tid[0], 2);
            check("idle_data", out_data[0], 'hA5);
            check("idle_latency", out_cyc[0] - last_in_cyc, 2);
        end

        // Fixed priority: channel 0 wins every cycle until it runs dry.
        cur = 0;
        do_reset(1'b0);
        for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < 12; k++) src_q[ch].push_back(mk(0, ch * 256 + k, 1'b1));
        for (int i = 0; i < 6; i++) cycle();
        check("fp_tready", s_ready[0], 4'b0001);
        drain(400);
        check("fp_count", out_tid.size(), 48);
        for (int k = 0; k < out_tid.size(); k++) check("fp_tid", out_tid[k], k / 12);

        // Round-robin with single-beat packets.
        cur = 1;
        do_reset(1'b0);
        for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < 8; k++) src_q[ch].push_back(mk(0, ch * 256 + k, 1'b1));
        drain(400);
        check("rr_count", out_tid.size(), 32);
        for (int k = 0; k < out_tid.size(); k++) check("rr_tid", out_tid[k], k % 4);
        if (out_cyc.size() == 32) check("rr_rate", out_cyc[31] - out_cyc[0], 31);

        // Packet lock: ch1 packet with a gap must not be interleaved with ch0.
        do_reset(1'b0);
        src_q[1].push_back(mk(0, 'h11, 1'b0));
        src_q[1].push_back(mk(0, 'h12, 1'b0));
        src_q[1].push_back(mk(2, 'h13, 1'b0));
        src_q[1].push_back(mk(0, 'h14, 1'b1));
        for (int k = 0; k < 6; k++) src_q[0].push_back(mk((k == 0) ? 1 : 0, k, 1'b1));
        drain(100);
        check("lock_count", out_tid.size(), 10);
        for (int k = 0; k < out_tid.size(); k++) check("lock_tid", out_tid[k], (k < 4) ? 1 : 0);
        for (int k = 0; k < 4 && k < out_data.size(); k++) check("lock_data", out_data[k], 'h11 + k);

        // Random backpressure with random packets on all channels.
        do_reset(1'b0);
        for (int i = 0; i < 1000; i++) begin
            src_q[$urandom_range(0, CH-1)].push_back(
                mk($urandom_range(0, 2), int'($urandom), ($urandom_range(0, 3) == 0)));
        end
        for (int ch = 0; ch < CH; ch++) begin
            if (src_q[ch].size() != 0) begin
                b = src_q[ch][$];
                b.last = 1'b1;
                src_q[ch][$] = b;
            end
        end
        rand_ready = 1'b1;
        drain(20000);
        rand_ready = 1'b0;
        check("bp_count", out_tid.size(), 1000);

        // Reset in the middle of a locked ch3 packet.
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) src_q[3].push_back(mk(0, 'h30 + k, (k == 3)));
        cycle();
        cycle();
        do_reset(1'b0);
        src_q[0].push_back(mk(0, 'h77, 1'b1));
        drain(20);
        for (int i = 0; i < 5; i++) cycle();
        check("mid_rst_count", out_tid.size(), 1);
        if (out_tid.size() == 1) begin
            check("mid_rst_tid", out_tid[0], 0);
            check("mid_rst_data", out_data[0], 'h77);
            check("mid_rst_latency", out_cyc[0] - last_in_cyc, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_join_arb.md
Name: axis_join_arb

Overview:
- N-input AXI-Stream join: generalised successor of the two-input priority join used in the datapath.
- Merges CH_NUM slave streams into one master stream.
- Arbitration is fixed-priority or round-robin; grant can be held for a whole packet (tlast).
- Output carries the source channel index (tid) so downstream routing logic can demultiplex.

Parameters:
- DATA_WD, 64, data width per channel in bits.
- CH_NUM, 4, number of slave channels (2..16).
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- PKT_LOCK, 1, 1 = hold grant until the tlast beat; 0 = re-arbitrate every beat.
- ID_WD, 2, tid width; must be max(1, clog2(CH_NUM)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- s_axis_tvalid  in  CH_NUM  per-channel valid.
- s_axis_tdata  in  CH_NUM*DATA_WD  channel i at bits [i*DATA_WD +: DATA_WD].
- s_axis_tlast  in  CH_NUM  per-channel end of packet.
- s_axis_tready  out  CH_NUM  per-channel ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_WD  output data.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tid  out  ID_WD  index of the channel that sourced the beat.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Clears all holding valids, data, lock flag, lock_ch and rr_ptr (to 0).
  - m_axis_tvalid/tdata/tlast/tid = 0.
  - s_axis_tready is forced to 0 while rst_n=0.
  - Reset mid-packet discards all held beats and the lock; no beat is emitted after reset release until new input arrives.
- Stage 1, one holding register per channel (hv[i], hd[i], hl[i]):
  - s_axis_tready[i] = !hv[i] | pop[i].
  - On s handshake, load tdata/tlast and set hv[i]=1; else if pop[i], clear hv[i].
  - Simultaneous pop and load in the same cycle gives back-to-back throughput.
- Output register:
  - out_ready = !m_axis_tvalid | m_axis_tready.
  - On pop, load data, last and tid=g, and set m_axis_tvalid=1.
  - Else if m_axis_tready, clear m_axis_tvalid.
  - m_axis_* stay stable while tvalid=1 and tready=0.
- Arbitration (combinational; grant g issued only when out_ready=1):
  - Eligible set = {i : hv[i]}.
  - If locked, eligible set = {lock_ch} only; other channels wait even if lock_ch is empty.
  - ARB_MODE=0: lowest eligible index.
  - ARB_MODE=1: first eligible index scanning rr_ptr, rr_ptr+1, ... modulo CH_NUM.
  - pop[g]=1 for exactly one channel per cycle at most.
- Lock and pointer update:
  - PKT_LOCK=1: pop of a non-last beat sets lock=1, lock_ch=g; pop of a last beat clears lock.
  - PKT_LOCK=0: lock is never set.
  - rr_ptr <= (g+1) mod CH_NUM on pop, only when the packet ends (last beat) if PKT_LOCK=1, or on every pop if PKT_LOCK=0.
- Latency and throughput:
  - Latency is 2 cycles: a beat accepted at edge t is valid on m at edge t+1 output, observed after edge t+2 of pop.
  - Minimum is s handshake at edge t → m_axis_tvalid asserted after edge t+1 when uncontended.
  - Aggregate throughput is 1 beat/clk.
- Fairness:
  - ARB_MODE=0 can starve higher indices; this is intended (control channel 0 has precedence).
  - ARB_MODE=1 guarantees each continuously valid channel one packet per CH_NUM packets.
- No beat is dropped, duplicated or reordered within a channel.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clk with all tvalid=1 → s_axis_tready=0, m_axis_tvalid=0. After release, single beat 0xA5 on ch2 → m_axis_tdata=0xA5, tid=2, 1 cycle after handshake.
- Fixed priority: ARB_MODE=0, PKT_LOCK=0, all 4 channels continuously valid with single-beat packets (tlast=1) → output tid sequence 0,0,0,... and s_axis_tready[3:1] deasserted after their holding registers fill.
- Round-robin: ARB_MODE=1, same stimulus → tid sequence 0,1,2,3,0,1,... at 1 beat/clk with m_axis_tready=1.
- Packet lock: PKT_LOCK=1, ch1 sends a 4-beat packet with a 2-cycle gap after beat 2, ch0 valid throughout → all 4 ch1 beats are contiguous on output with no ch0 beat interleaved; ch0 is granted only after the ch1 tlast beat.
- Backpressure: random m_axis_tready (50%), 1000 random beats across channels → scoreboard per tid matches input order exactly; m_axis_* stable while stalled.
- Reset mid-packet: assert rst_n=0 during beat 2 of a locked ch3 packet → lock cleared; after release ch0 is granted immediately; no stale ch3 beat appears.
